// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared helpers for the pipelined adder/subtractor. Provides
//                the chunk-width arithmetic used to slice a WIDTH-bit operand
//                into STAGES pipeline chunks, and the add/sub op encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Operation encoding carried on the 'sub' input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk width: ceil(width / stages).
    function automatic int addsub_cw(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Width of the final (remainder) chunk; must come out >= 1.
    function automatic int addsub_last_w(input int width, input int stages);
        return width - (stages - 1) * addsub_cw(width, stages);
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/pipelined_addsub_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_add_stage
//  Description : One pipeline stage of the chunked adder. Adds operand chunk
//                IDX (bits [IDX*CW +: CHW]) with the incoming carry, merges the
//                chunk sum into the partial result and registers everything
//                behind a valid/ready handshake with bubble collapsing.
//                The final instance (IS_LAST) turns the raw carry into
//                carry/borrow on o_cout; o_ovf is meaningful only there.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_valid/o_ready   - upstream handshake
//                i_a, i_b          - operand A and effective operand B
//                i_s               - partial result (chunk IDX bits are zero)
//                i_c, i_sub        - carry into this chunk, op flag
//                o_valid/i_ready   - downstream handshake
//                o_a, o_b, o_s     - registered operands / partial result
//                o_c               - registered raw carry out of chunk IDX
//                o_sub             - registered op flag
//                o_cout, o_ovf     - carry/borrow and signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_add_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CW      = 8,
    parameter int IDX     = 0,
    parameter int CHW     = 8,
    parameter bit IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_s,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_sub,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int c_lo  = IDX * CW;
    localparam int c_msb = c_lo + CHW - 1;

    logic             r_valid_q, w_valid_d;
    logic [WIDTH-1:0] r_a_q, w_a_d;
    logic [WIDTH-1:0] r_b_q, w_b_d;
    logic [WIDTH-1:0] r_s_q, w_s_d;
    logic             r_c_q, w_c_d;
    logic             r_sub_q, w_sub_d;
    logic             r_ovf_q, w_ovf_d;

    logic [CHW:0]     w_sum;
    logic             w_ready;
    logic             w_load;

    // A stage can take a new beat when empty or when its content moves on.
    assign w_ready = !r_valid_q || i_ready;
    assign w_load  = i_valid && w_ready;

    always_comb begin
        w_sum     = {1'b0, i_a[c_lo +: CHW]} + {1'b0, i_b[c_lo +: CHW]}
                  + {{CHW{1'b0}}, i_c};
        w_valid_d = r_valid_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_s_d     = r_s_q;
        w_c_d     = r_c_q;
        w_sub_d   = r_sub_q;
        w_ovf_d   = r_ovf_q;
        if (w_ready) begin
            w_valid_d = i_valid;
        end
        if (w_load) begin
            w_a_d   = i_a;
            w_b_d   = i_b;
            // Chunk IDX of the incoming partial result is still zero, so an
            // OR drops the new chunk into place.
            w_s_d   = i_s | (WIDTH'(w_sum[CHW-1:0]) << c_lo);
            w_c_d   = w_sum[CHW];
            w_sub_d = i_sub;
            // Sign-bit overflow rule on this chunk's top bit; at the final
            // chunk this is the operand MSB.
            w_ovf_d = (i_a[c_msb] == i_b[c_msb]) && (w_sum[CHW-1] != i_a[c_msb]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_s_q     <= '0;
            r_c_q     <= 1'b0;
            r_sub_q   <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_valid_q <= w_valid_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_s_q     <= w_s_d;
            r_c_q     <= w_c_d;
            r_sub_q   <= w_sub_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid_q;
    assign o_a     = r_a_q;
    assign o_b     = r_b_q;
    assign o_s     = r_s_q;
    assign o_c     = r_c_q;
    assign o_sub   = r_sub_q;
    assign o_ovf   = r_ovf_q;

    // Subtraction runs as A + ~B + ~cin, so the raw carry is the inverse of
    // the borrow.
    if (IS_LAST) begin : g_last
        assign o_cout = (r_sub_q == OP_SUB) ? ~r_c_q : r_c_q;
    end else begin : g_mid
        assign o_cout = r_c_q;
    end

endmodule : pipe_add_stage
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_addsub
//  Description : Parametrised pipelined adder/subtractor. WIDTH-bit operands
//                are split into STAGES chunks of ceil(WIDTH/STAGES) bits; each
//                stage resolves one chunk and hands its carry to the next.
//                Valid/ready on both sides, one result per cycle, latency
//                STAGES cycles.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid/in_ready    - operand handshake
//                a, b, cin, sub       - operands; sub=0: A+B+cin, 1: A-B-cin
//                out_valid/out_ready  - result handshake
//                s, cout, ovf         - result, carry/borrow, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_cw     = addsub_cw(WIDTH, STAGES);
    localparam int c_last_w = addsub_last_w(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || c_last_w < 1) begin : g_param_check
        $error("pipelined_addsub: illegal WIDTH/STAGES combination");
    end

    // Index k is the input of stage k; index STAGES is the pipeline output.
    logic [STAGES:0]            w_valid;
    logic [STAGES:0]            w_ready;
    logic [STAGES:0][WIDTH-1:0] w_a;
    logic [STAGES:0][WIDTH-1:0] w_b;
    logic [STAGES:0][WIDTH-1:0] w_s;
    logic [STAGES:0]            w_c;
    logic [STAGES:0]            w_sub;
    logic [STAGES-1:0]          w_cout;
    logic [STAGES-1:0]          w_ovf;
    logic                       w_unused_tail;

    assign w_valid[0]      = in_valid;
    assign w_a[0]          = a;
    assign w_b[0]          = (sub == OP_ADD) ? b : ~b;
    assign w_c[0]          = (sub == OP_ADD) ? cin : ~cin;
    assign w_sub[0]        = sub;
    assign w_s[0]          = '0;
    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_add_stage #(
            .WIDTH   (WIDTH),
            .CW      (c_cw),
            .IDX     (k),
            .CHW     ((k == STAGES - 1) ? c_last_w : c_cw),
            .IS_LAST (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_s     (w_s[k]),
            .i_c     (w_c[k]),
            .i_sub   (w_sub[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_s     (w_s[k+1]),
            .o_c     (w_c[k+1]),
            .o_sub   (w_sub[k+1]),
            .o_cout  (w_cout[k]),
            .o_ovf   (w_ovf[k])
        );
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[STAGES];
    assign s         = w_s[STAGES];
    assign cout      = w_cout[STAGES-1];
    assign ovf       = w_ovf[STAGES-1];

    // Operands leaving the last stage and the per-chunk flags of the inner
    // stages have no consumer.
    assign w_unused_tail = ^{w_a[STAGES], w_b[STAGES], w_c[STAGES],
                             w_sub[STAGES], w_cout, w_ovf};

endmodule : pipelined_addsub
`default_nettype wire
